// File: rtl/pipo_load_arbiter.sv
// Two-requester round-robin arbiter that loads a shared N-bit register on the falling edge of CLK_BAR.
// After each load it holds for HOLD_CYC cycles. Defining PIPO_ARB_LOAD_COUNT_EN adds an 8-bit load_count output.
module pipo_load_arbiter #(
    parameter int unsigned N        = 8,
    parameter int unsigned HOLD_CYC = 2
) (
    input  logic         CLK_BAR,
    input  logic         CLR_BAR,
    input  logic         req_a,
    input  logic [N-1:0] data_a,
    input  logic         req_b,
    input  logic [N-1:0] data_b,
    output logic         ack_a,
    output logic         ack_b,
    output logic [N-1:0] data_out,
    output logic         owner,
    output logic         busy
`ifdef PIPO_ARB_LOAD_COUNT_EN
    ,
    output logic [7:0]   load_count
`endif
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_HOLD   = 1'b1;
    localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYC);

    logic [0:0] state;
    logic [3:0] hold_cnt;
    logic       last_b;
    logic       load;
    logic       grant_b;

    // A tie goes to the requester that was not served last.
    always_comb begin
        load    = (state == ST_IDLE) && (req_a || req_b);
        grant_b = req_b && !(req_a && last_b);
    end

    always_ff @(negedge CLK_BAR or negedge CLR_BAR) begin
        if (!CLR_BAR) begin
            state    <= ST_IDLE;
            hold_cnt <= 4'd0;
            last_b   <= 1'b1;
            data_out <= '0;
            owner    <= 1'b0;
            ack_a    <= 1'b0;
            ack_b    <= 1'b0;
        end else begin
            ack_a <= 1'b0;
            ack_b <= 1'b0;
            if (load) begin
                data_out <= grant_b ? data_b : data_a;
                owner    <= grant_b;
                ack_a    <= !grant_b;
                ack_b    <= grant_b;
                last_b   <= grant_b;
                state    <= ST_HOLD;
                hold_cnt <= HOLD_INIT;
            end else if (state == ST_HOLD) begin
                hold_cnt <= hold_cnt - 4'd1;
                if (hold_cnt == 4'd1) begin
                    state <= ST_IDLE;
                end
            end
        end
    end

    assign busy = (state == ST_HOLD);

`ifdef PIPO_ARB_LOAD_COUNT_EN
    always_ff @(negedge CLK_BAR or negedge CLR_BAR) begin
        if (!CLR_BAR) begin
            load_count <= 8'd0;
        end else if (load) begin
            load_count <= load_count + 8'd1;
        end
    end
`endif

endmodule
